// File: rtl/product_bcd_conv.sv
// rtl/product_bcd_conv.sv - signed product to sign + BCD digits, one double-dabble step per clock
module product_bcd_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rdy,
    input  logic [WIDTH-1:0]      i_product,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic                  o_sign,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              sign_q, sign_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [BW-1:0]     out_bcd_q, out_bcd_d;
    logic              out_sign_q, out_sign_d;
    logic              valid_q, valid_d;

    logic              start;
    logic [WIDTH-1:0]  src;
    logic [BW-1:0]     bcd_adj;
    logic [BW+WIDTH-1:0] shifted;

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        out_bcd_d  = out_bcd_q;
        out_sign_d = out_sign_q;
        valid_d    = 1'b0;
        start      = 1'b0;
        src        = i_product;
        bcd_adj    = bcd_q;
        shifted    = '0;

        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_rdy) begin
                    start = 1'b1;
                end
            end
            S_CONV: begin
                shifted = {bcd_adj, mag_q} << 1;
                bcd_d   = shifted[BW+WIDTH-1:WIDTH];
                mag_d   = shifted[WIDTH-1:0];
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
                if (i_rdy) begin
                    pend_d   = i_product;
                    pend_v_d = 1'b1;
                end
            end
            S_DONE: begin
                out_bcd_d  = bcd_q;
                out_sign_d = sign_q;
                valid_d    = 1'b1;
                // Buffered product takes precedence; a same-edge i_rdy refills the slot.
                if (pend_v_q) begin
                    start    = 1'b1;
                    src      = pend_q;
                    pend_v_d = i_rdy;
                    if (i_rdy) begin
                        pend_d = i_product;
                    end
                end else if (i_rdy) begin
                    start = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            sign_d  = src[WIDTH-1];
            mag_d   = src[WIDTH-1] ? (~src + 1'b1) : src;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = S_CONV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            out_bcd_q  <= '0;
            out_sign_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            out_bcd_q  <= out_bcd_d;
            out_sign_q <= out_sign_d;
            valid_q    <= valid_d;
        end
    end

    assign o_busy  = (state_q != S_IDLE);
    assign o_valid = valid_q;
    assign o_sign  = out_sign_q;
    assign o_bcd   = out_bcd_q;

endmodule

// File: tb/tb_product_bcd_conv.sv
// tb/tb_product_bcd_conv.sv - directed scoreboard bench for product_bcd_conv
module tb_product_bcd_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_rdy = 1'b0;
    logic [15:0] i_product = '0;
    logic        o_busy;
    logic        o_valid;
    logic        o_sign;
    logic [19:0] o_bcd;

    product_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_rdy     (i_rdy),
        .i_product (i_product),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_sign    (o_sign),
        .o_bcd     (o_bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        logic        sign;
        logic [19:0] bcd;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          e0;
    logic        prev_v = 1'b0;
    logic        last_sign = 1'b0;
    logic [19:0] last_bcd = '0;

    logic [15:0] bnd_in  [4];
    logic        bnd_sgn [4];
    logic [19:0] bnd_bcd [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic was_rst;
        was_rst = rst;
        @(posedge clk);
        #1;
        edge_n++;
        if (was_rst) begin
            last_bcd  = '0;
            last_sign = 1'b0;
        end
        chk("valid_pulse_width", {31'd0, prev_v & o_valid}, 32'd0);
        if (o_valid) begin
            chk("valid_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("valid_edge", edge_n, e.edge_no);
                chk("sign", {31'd0, o_sign}, {31'd0, e.sign});
                chk("bcd", {12'd0, o_bcd}, {12'd0, e.bcd});
                last_bcd  = e.bcd;
                last_sign = e.sign;
            end
        end else begin
            chk("hold_bcd", {12'd0, o_bcd}, {12'd0, last_bcd});
            chk("hold_sign", {31'd0, o_sign}, {31'd0, last_sign});
        end
        prev_v = o_valid;
    endtask

    task automatic pulse(input logic [15:0] p);
        i_rdy     = 1'b1;
        i_product = p;
        tick();
        i_rdy     = 1'b0;
    endtask

    task automatic push(input int ed, input logic s, input logic [19:0] b);
        exp_t e;
        e.edge_no = ed;
        e.sign    = s;
        e.bcd     = b;
        q.push_back(e);
    endtask

    task automatic drain(input int max_ticks);
        int n;
        n = 0;
        while ((q.size() != 0 || o_busy) && n < max_ticks) begin
            tick();
            n++;
        end
        chk("drain_timeout", {31'd0, n < max_ticks}, 32'd1);
    endtask

    initial begin
        bnd_in[0] = 16'h4000; bnd_sgn[0] = 1'b0; bnd_bcd[0] = 20'h16384;
        bnd_in[1] = 16'h0000; bnd_sgn[1] = 1'b0; bnd_bcd[1] = 20'h00000;
        bnd_in[2] = 16'h8000; bnd_sgn[2] = 1'b1; bnd_bcd[2] = 20'h32768;
        bnd_in[3] = 16'h7FFF; bnd_sgn[3] = 1'b0; bnd_bcd[3] = 20'h32767;

        // Reset with i_rdy asserted: nothing may start.
        rst = 1'b1; i_rdy = 1'b1; i_product = 16'hFFC7;
        tick();
        tick();
        chk("rst_bcd", {12'd0, o_bcd}, 32'd0);
        chk("rst_sign", {31'd0, o_sign}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0; i_rdy = 1'b0;
        tick();
        chk("post_rst_busy", {31'd0, o_busy}, 32'd0);

        // -57
        pulse(16'hFFC7);
        chk("busy_after_capture", {31'd0, o_busy}, 32'd1);
        push(edge_n + 17, 1'b1, 20'h00057);
        drain(40);
        repeat (3) tick();

        // -2870
        pulse(16'hF4CA);
        push(edge_n + 17, 1'b1, 20'h02870);
        drain(40);

        for (int i = 0; i < 4; i++) begin
            pulse(bnd_in[i]);
            push(edge_n + 17, bnd_sgn[i], bnd_bcd[i]);
            drain(40);
            tick();
        end

        // Pending slot: 1234, then -99 overwritten by 77.
        pulse(16'h04D2);
        e0 = edge_n;
        push(e0 + 17, 1'b0, 20'h01234);
        push(e0 + 34, 1'b0, 20'h00077);
        for (int k = 1; k <= 34; k++) begin
            if (k == 5) begin
                i_rdy = 1'b1; i_product = 16'hFF9D;
            end else if (k == 8) begin
                i_rdy = 1'b1; i_product = 16'h004D;
            end else begin
                i_rdy = 1'b0;
            end
            tick();
            if (k <= 33) chk("busy_b2b", {31'd0, o_busy}, 32'd1);
        end
        i_rdy = 1'b0;
        chk("busy_end_b2b", {31'd0, o_busy}, 32'd0);
        drain(40);
        tick();

        // Reset mid-conversion aborts, then a fresh 500.
        pulse(16'hF4CA);
        for (int k = 1; k <= 12; k++) begin
            rst   = (k == 10);
            i_rdy = 1'b0;
            if (k == 12) begin
                i_rdy = 1'b1; i_product = 16'h01F4;
            end
            tick();
            if (k == 10) begin
                chk("abort_bcd", {12'd0, o_bcd}, 32'd0);
                chk("abort_sign", {31'd0, o_sign}, 32'd0);
                chk("abort_valid", {31'd0, o_valid}, 32'd0);
                chk("abort_busy", {31'd0, o_busy}, 32'd0);
            end
        end
        rst = 1'b0; i_rdy = 1'b0;
        push(edge_n + 17, 1'b0, 20'h00500);
        drain(40);
        repeat (3) tick();
        chk("queue_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_bcd_conv.md
# product_bcd_conv

Sequential signed binary-to-BCD converter sitting directly downstream of the Booth multiplier. It captures the 16-bit two's-complement product on the multiplier's ready pulse and separates out a sign flag. It converts the magnitude to five BCD digits with a shift-add-3 (double-dabble) iteration, one bit per clock. The digit/sign results feed the seven-segment encoders for the sign, ones, tens, hundreds, thousands and ten-thousands displays.

## Interface
- WIDTH, 16, product width in bits (two's complement).
- DIGITS, 5, BCD digits produced. Requires 10^DIGITS > 2^(WIDTH-1).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_rdy  in  1  product-valid pulse from multiplier; i_product sampled on any edge where i_rdy=1.
- i_product  in  WIDTH  signed product.
- o_busy  out  1  conversion in progress.
- o_valid  out  1  one-cycle pulse: o_bcd/o_sign just updated.
- o_sign  out  1  1 = result negative.
- o_bcd  out  4*DIGITS  magnitude digits; digit k at [4k+3:4k], k=0 ones.

## Operation
- State machine states:
  - IDLE: on i_rdy, load the magnitude shift register with |i_product| and latch the sign, then go to CONV.
  - CONV: WIDTH iterations, then go to DONE.
  - DONE: publish results. If a pending entry exists, restart from it; otherwise, if i_rdy, restart from i_product; otherwise return to IDLE.
- Sign/magnitude at capture:
  - sign = i_product[WIDTH-1].
  - mag = sign ? (~i_product + 1) : i_product, as a WIDTH-bit unsigned value.
  - -2^(WIDTH-1) gives mag = 2^(WIDTH-1), which is legal.
  - Zero gives sign 0.
- CONV iteration, one per cycle:
  - Every BCD working digit >= 5 gets +3.
  - Then {bcd_work, mag} shifts left by 1.
  - A 5-bit iteration counter counts 0..WIDTH-1 and is cleared on every capture.
- DONE edge:
  - o_bcd <= bcd_work and o_sign <= captured sign.
  - o_valid = 1 for exactly one cycle.
- o_bcd/o_sign hold their last published value until the next DONE. They never show intermediate values.
- Single-entry pending buffer:
  - i_rdy sampled while state is CONV or DONE writes {i_product} into pending and sets pending_v.
  - A newer write overwrites an older one, so only the latest is kept.
  - At the DONE edge with pending_v=1: start from pending and clear pending_v. If i_rdy is also high that edge, it refills pending and pending_v stays 1.
  - At the DONE edge with pending_v=0 and i_rdy=1: start directly from i_rdy; pending is untouched.
- o_busy = 1 in CONV and DONE, and stays high continuously across back-to-back restarts.
- Reset (any state, including mid-conversion):
  - Go to IDLE; o_bcd=0, o_sign=0, o_valid=0, o_busy=0; pending_v=0; counter=0.
  - An aborted conversion never produces o_valid.
  - rst has priority over i_rdy on the same edge.

## Timing
- Edge E0 samples i_rdy=1 in IDLE. Capture happens and o_busy=1 after E0.
- Edges E1..E16 perform the 16 iterations (WIDTH=16).
- Edge E17 is the DONE edge. After it: o_valid=1 and o_bcd/o_sign are new; o_busy=0 unless restarting.
- Latency: i_rdy sample to o_valid = WIDTH+1 = 17 cycles.
- Throughput: one result per WIDTH+1 cycles with back-to-back restart.
- i_rdy held high multiple cycles is treated as repeated products; the last one sampled before DONE wins the pending slot.
- No backpressure: o_valid is not acknowledged, and the consumer must latch on the pulse.

## Test plan
- Reset: rst=1 for 2 cycles with i_rdy=1 -> o_bcd=0x00000, o_sign=0, o_valid=0, o_busy=0; no conversion starts.
- Product -1*57: i_product=16'hFFC7 pulse -> o_valid exactly 17 cycles later, o_sign=1, o_bcd=20'h00057; o_valid high 1 cycle; outputs hold afterwards.
- Product -35*82: i_product=16'hF4CA -> o_sign=1, o_bcd=20'h02870.
- Boundaries, one conversion each:
  - 16'h4000 (-128*-128) -> sign 0, 20'h16384.
  - 16'h0000 -> sign 0, 20'h00000.
  - 16'h8000 -> sign 1, 20'h32768.
  - 16'h7FFF -> sign 0, 20'h32767.
- Buffering: i_rdy with 1234 at cycle 0, -99 at cycle 5, 77 at cycle 8.
  - Expected o_valid at cycle 17 with 20'h01234, sign 0.
  - Expected o_valid at cycle 34 with 20'h00077, sign 0.
  - -99 is never output and o_busy stays high cycles 1..34.
- Reset mid-conversion: i_rdy with -2870 at cycle 0, rst=1 at cycle 10 -> no o_valid; all outputs 0. A new i_rdy with 500 at cycle 12 -> o_valid at cycle 29, 20'h00500, sign 0.
